// File: rtl/trace_chk_pkg.sv
// Shared types for the writeback-trace checker: FSM states, error codes and
// the 70-bit expected-trace entry.
package trace_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ERROR = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_PC        = 3'd2;
    localparam logic [2:0] ERR_WNUM      = 3'd3;
    localparam logic [2:0] ERR_WDATA     = 3'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        last;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of expected trace entries; pointers carry one extra wrap
// bit so full and empty are distinguishable without an occupancy counter.
module trace_fifo
    import trace_chk_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  trace_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output trace_entry_t head
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    trace_entry_t mem [FIFO_DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_trace_checker.sv
// Compares each committed register write from the core trace against the
// buffered expected trace. Optional: TRACE_CHK_STOP_ON_ERR_EN (ERROR terminal).
module wb_trace_checker
    import trace_chk_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      debug_wb_pc,
    input  logic [3:0]       debug_wb_rf_we,
    input  logic [4:0]       debug_wb_rf_wnum,
    input  logic [31:0]      debug_wb_rf_wdata,
    input  logic             ref_valid,
    output logic             ref_ready,
    input  logic [31:0]      ref_pc,
    input  logic [4:0]       ref_wnum,
    input  logic [31:0]      ref_wdata,
    input  logic             ref_last,
    output logic [1:0]       chk_state,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [31:0]      err_pc,
    output logic [31:0]      err_exp_pc,
    output logic [15:0]      err_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             pass
);

`ifdef TRACE_CHK_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    chk_state_t   state, next_state;
    trace_entry_t head;
    trace_entry_t push_data;
    logic         fifo_full, fifo_empty;
    logic         commit, active, push, pop;
    logic         is_err, is_match;
    logic [2:0]   cur_code;

    assign commit    = (|debug_wb_rf_we) && (debug_wb_rf_wnum != 5'd0);
    assign active    = (state != ST_DONE) && !(STOP_ON_ERR && state == ST_ERROR);
    assign ref_ready = !fifo_full && !(STOP_ON_ERR && state == ST_ERROR);
    assign push      = ref_valid && ref_ready;
    assign push_data = '{pc: ref_pc, wnum: ref_wnum, wdata: ref_wdata, last: ref_last};

    trace_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Compare is purely on the FIFO head; a same-cycle push is never visible here.
    always_comb begin
        cur_code   = ERR_NONE;
        pop        = 1'b0;
        is_err     = 1'b0;
        is_match   = 1'b0;
        next_state = state;
        if (commit && active) begin
            if (fifo_empty) begin
                cur_code = ERR_UNDERFLOW;
            end else begin
                pop = 1'b1;
                if (head.pc != debug_wb_pc)                 cur_code = ERR_PC;
                else if (head.wnum != debug_wb_rf_wnum)     cur_code = ERR_WNUM;
                else if (head.wdata != debug_wb_rf_wdata)   cur_code = ERR_WDATA;
            end
            is_err   = (cur_code != ERR_NONE);
            is_match = !is_err;
        end
        if (is_err)
            next_state = ST_ERROR;
        else if (is_match && head.last)
            next_state = ST_DONE;
        else if (state == ST_IDLE && (push || !fifo_empty))
            next_state = ST_RUN;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_pc     <= '0;
            err_exp_pc <= '0;
            err_cnt    <= '0;
            match_cnt  <= '0;
        end else begin
            state <= next_state;
            if (is_err && !err) begin
                err        <= 1'b1;
                err_code   <= cur_code;
                err_pc     <= debug_wb_pc;
                err_exp_pc <= fifo_empty ? 32'd0 : head.pc;
            end
            if (is_err && err_cnt != '1)     err_cnt   <= err_cnt + 1'b1;
            if (is_match && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end
    end

    assign chk_state = state;
    assign done      = (state == ST_DONE);
    assign pass      = done && (err_cnt == '0);

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker (default build, non-stop error mode).
module tb_wb_trace_checker;
    import trace_chk_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        ref_valid, ref_ready;
    logic [31:0] ref_pc, ref_wdata;
    logic [4:0]  ref_wnum;
    logic        ref_last;
    logic [1:0]  chk_state;
    logic        err, done, pass;
    logic [2:0]  err_code;
    logic [31:0] err_pc, err_exp_pc;
    logic [15:0] err_cnt;
    logic [31:0] match_cnt;

    int checks = 0;
    int errors = 0;

    wb_trace_checker #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .ref_valid(ref_valid), .ref_ready(ref_ready),
        .ref_pc(ref_pc), .ref_wnum(ref_wnum), .ref_wdata(ref_wdata), .ref_last(ref_last),
        .chk_state(chk_state), .err(err), .err_code(err_code),
        .err_pc(err_pc), .err_exp_pc(err_exp_pc), .err_cnt(err_cnt),
        .match_cnt(match_cnt), .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  we;
        logic [4:0]  wn;
        logic [31:0] pc, wd;
        logic        rv;
        int          ref_idx;
        logic [1:0]  st;
        logic        rdy, er;
        logic [2:0]  code;
        logic [31:0] mcnt;
        logic [15:0] ecnt;
        logic        dn, ps;
        logic [31:0] epc, eexp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] epc_of(int i);
        return 32'h1c00_0000 + 32'(4 * i);
    endfunction
    function automatic logic [4:0]  ewn_of(int i);
        return 5'(i + 1);
    endfunction
    function automatic logic [31:0] ewd_of(int i);
        return 32'(16 * (i + 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] we, input logic [4:0] wn, input logic [31:0] pc,
                         input logic [31:0] wd, input logic rv, input int idx, input logic last);
        debug_wb_rf_we    = we;
        debug_wb_rf_wnum  = wn;
        debug_wb_pc       = pc;
        debug_wb_rf_wdata = wd;
        ref_valid         = rv;
        ref_pc            = epc_of(idx);
        ref_wnum          = ewn_of(idx);
        ref_wdata         = ewd_of(idx);
        ref_last          = last;
    endtask

    task automatic idle_inputs();
        drive(4'h0, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
    endtask

    task automatic commit_entry(input int i);
        drive(4'hf, ewn_of(i), epc_of(i), ewd_of(i), 1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rst, we, wn, pc, wd, rv, ref_idx | st, rdy, err, code, mcnt, ecnt, done, pass, epc, eexp
    function automatic vec_t mk(logic rst, logic [3:0] we, logic [4:0] wn, logic [31:0] pc,
                                logic [31:0] wd, logic rv, int ri, logic [1:0] st, logic rdy,
                                logic er, logic [2:0] code, logic [31:0] mcnt, logic [15:0] ecnt,
                                logic dn, logic ps, logic [31:0] epc, logic [31:0] eexp);
        vec_t v;
        v.rst = rst; v.we = we; v.wn = wn; v.pc = pc; v.wd = wd; v.rv = rv; v.ref_idx = ri;
        v.st = st; v.rdy = rdy; v.er = er; v.code = code; v.mcnt = mcnt; v.ecnt = ecnt;
        v.dn = dn; v.ps = ps; v.epc = epc; v.eexp = eexp;
        return v;
    endfunction

    initial begin
        resetn = 1'b0;
        idle_inputs();
        #3;
        chk("reset_state", 32'(chk_state), 32'd0);
        chk("reset_ready", 32'(ref_ready), 32'd1);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_code", 32'(err_code), 32'd0);
        chk("reset_match", match_cnt, 32'd0);
        chk("reset_errcnt", 32'(err_cnt), 32'd0);
        chk("reset_done_pass", 32'({done, pass}), 32'd0);
        chk("reset_errpcs", err_pc | err_exp_pc, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Matched run, filtered events, commit in DONE.
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 0,  2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1,  2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 2,  2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hf, 1, 32'h1c000000, 32'h10, 0, 0, 2'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hf, 2, 32'h1c000004, 32'h20, 0, 0, 2'd1, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 3, 32'h1c000008, 32'h30, 0, 0, 2'd1, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hf, 0, 32'h1c000008, 32'h30, 0, 0, 2'd1, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h1, 3, 32'h1c000008, 32'h30, 0, 0, 2'd3, 1, 0, 0, 3, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 4'hf, 5, 32'h0000dead, 32'h99, 0, 0, 2'd3, 1, 0, 0, 3, 0, 1, 1, 0, 0));
        // Data mismatch, then underflow while already in ERROR (first error held).
        vecs.push_back(mk(1, 4'h0, 0, 0, 0, 1, 0,  2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 1,  2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 0, 1, 2,  2'd1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hf, 1, 32'h1c000000, 32'h10, 0, 0, 2'd1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hf, 2, 32'h1c000004, 32'h20, 0, 0, 2'd1, 1, 0, 0, 2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'hf, 3, 32'h1c000008, 32'h31, 0, 0, 2'd2, 1, 1, 4, 2, 1, 0, 0,
                          32'h1c000008, 32'h1c000008));
        vecs.push_back(mk(0, 4'hf, 4, 32'h1c00000c, 32'h40, 0, 0, 2'd2, 1, 1, 4, 2, 2, 0, 0,
                          32'h1c000008, 32'h1c000008));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wn, vecs[i].pc, vecs[i].wd, vecs[i].rv,
                  vecs[i].ref_idx, vecs[i].ref_idx == 2);
            step();
            chk($sformatf("v%0d_state", i), 32'(chk_state), 32'(vecs[i].st));
            chk($sformatf("v%0d_ready", i), 32'(ref_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].er));
            chk($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].code));
            chk($sformatf("v%0d_match", i), match_cnt, vecs[i].mcnt);
            chk($sformatf("v%0d_errcnt", i), 32'(err_cnt), 32'(vecs[i].ecnt));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].ps));
            chk($sformatf("v%0d_errpc", i), err_pc, vecs[i].epc);
            chk($sformatf("v%0d_errexp", i), err_exp_pc, vecs[i].eexp);
        end

        // Underflow: commit with empty FIFO in the same cycle as the first push.
        do_reset();
        @(negedge clk);
        drive(4'hf, ewn_of(0), epc_of(0), ewd_of(0), 1'b1, 0, 1'b0);
        step();
        chk("uf_code", 32'(err_code), 32'(ERR_UNDERFLOW));
        chk("uf_exp_pc", err_exp_pc, 32'd0);
        chk("uf_err_pc", err_pc, 32'h1c000000);
        chk("uf_state", 32'(chk_state), 32'd2);
        chk("uf_match", match_cnt, 32'd0);
        @(negedge clk);
        commit_entry(0);
        step();
        chk("uf_entry_kept_match", match_cnt, 32'd1);
        chk("uf_code_held", 32'(err_code), 32'(ERR_UNDERFLOW));

        // Full FIFO: 8 pushes, then pop with a blocked push offered.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(4'h0, 5'd0, 32'd0, 32'd0, 1'b1, i, 1'b0);
            step();
        end
        chk("full_ready", 32'(ref_ready), 32'd0);
        chk("full_state", 32'(chk_state), 32'd1);
        @(negedge clk);
        drive(4'hf, ewn_of(0), epc_of(0), ewd_of(0), 1'b1, 64, 1'b0);
        step();
        chk("full_pop_ready", 32'(ref_ready), 32'd1);
        chk("full_pop_match", match_cnt, 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            commit_entry(i);
            step();
        end
        chk("full_drain_match", match_cnt, 32'd8);
        chk("full_drain_err", 32'(err), 32'd0);
        @(negedge clk);
        commit_entry(64);
        step();
        chk("full_no_push_code", 32'(err_code), 32'(ERR_UNDERFLOW));

        // Asynchronous reset mid-RUN with 5 entries buffered.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(4'h0, 5'd0, 32'd0, 32'd0, 1'b1, i, 1'b0);
            step();
        end
        @(negedge clk);
        commit_entry(0);
        step();
        chk("ar_pre_match", match_cnt, 32'd1);
        chk("ar_pre_state", 32'(chk_state), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("ar_state", 32'(chk_state), 32'd0);
        chk("ar_match", match_cnt, 32'd0);
        chk("ar_ready", 32'(ref_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
        @(negedge clk);
        commit_entry(1);
        step();
        chk("ar_fifo_empty_code", 32'(err_code), 32'(ERR_UNDERFLOW));
        chk("ar_fifo_empty_match", match_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_trace_checker.md
# wb_trace_checker

Synthesizable writeback-trace checker that consumes the `debug_wb_*` trace produced by the CPU core and compares every committed register write against an expected trace streamed in over a valid/ready port. It sits beside the core in the SoC-lite top and is the reading end of the core's trace interface. Expected entries are buffered in a small FIFO. The block reports pass/fail, the first mismatch, and running match and error counts.

## Interface
- `FIFO_DEPTH`, 8: expected-entry buffer depth; power of two, at least 2.
- `CNT_W`, 32: width of `match_cnt`.
- `clk` in 1: clock.
- `resetn` in 1: reset, asynchronous assert, active-low.
- `debug_wb_pc` in 32: PC of the retiring instruction.
- `debug_wb_rf_we` in 4: register-file write enable from the core; any set bit counts as a write.
- `debug_wb_rf_wnum` in 5: destination register number.
- `debug_wb_rf_wdata` in 32: value written to the register file.
- `ref_valid` in 1: expected entry offered.
- `ref_ready` out 1: checker accepts the entry; equals `!fifo_full`, and is 0 in ERROR in stop mode.
- `ref_pc`, `ref_wnum`, `ref_wdata` in 32/5/32: expected trace fields.
- `ref_last` in 1: marks the final expected entry.
- `chk_state` out 2: current FSM state.
- `err` out 1: sticky; at least one mismatch has occurred.
- `err_code` out 3: 0 none, 1 UNDERFLOW, 2 PC, 3 WNUM, 4 WDATA; holds the first error.
- `err_pc`, `err_exp_pc` out 32/32: actual and expected PC of the first error.
- `err_cnt` out 16: number of errors, saturating.
- `match_cnt` out CNT_W: number of matched commits, saturating.
- `done` out 1: the entry flagged `ref_last` has been consumed.
- `pass` out 1: `done` is set and `err_cnt` is 0.

## Operation
- A **commit event** is `(|debug_wb_rf_we) && debug_wb_rf_wnum != 0`. No other cycle is examined.
- **Push:** an entry is pushed into the FIFO when `ref_valid && ref_ready`.
- **Pop and compare:** each commit event pops the FIFO head and compares it with the trace.
- **Error priority:** UNDERFLOW (FIFO empty at commit) > PC > WNUM > WDATA. Only the highest-priority error of a commit is recorded.
- **FSM states:** IDLE=0, RUN=1, ERROR=2, DONE=3.
  - IDLE → RUN when the FIFO becomes non-empty.
  - A commit event in IDLE is an UNDERFLOW error and moves to ERROR.
  - RUN → ERROR on any mismatch or underflow.
  - RUN → DONE on a matching commit whose head entry has `ref_last` set.
  - Commits in DONE are ignored.
- **First error:** `err_code`, `err_pc` and `err_exp_pc` capture the first error only. They are not overwritten until reset. On UNDERFLOW, `err_exp_pc` is 0.
- **Counters:** `match_cnt` and `err_cnt` saturate at all-ones and never wrap.
- **FIFO pointers:** one extra bit is used for full/empty detection; pointers wrap modulo `2*FIFO_DEPTH`.

## Timing
- **Reset (asynchronous, `resetn` low):**
  - `chk_state`=IDLE, FIFO empty.
  - `ref_ready`=1.
  - All other outputs 0.
  - Reset mid-test discards buffered entries immediately.
- **Latency:** the compare is combinational on the FIFO head. `err`, `err_*`, the counters, `done`, `pass` and the state all update on the clock edge that ends the commit cycle (one-cycle latency).
- **Empty FIFO, push and commit in the same cycle:** UNDERFLOW. There is no bypass from `ref_*` to the compare.
- **Full FIFO:** `ref_ready`=0, so there is no push. A commit in the same cycle pops, and `ref_ready` returns to 1 next cycle.
- **Non-full FIFO, push and pop in the same cycle:** occupancy is unchanged.
- **Entry with `ref_last`:** once it is pushed, further pushes are still accepted but are never compared after DONE.

## Configuration
- `TRACE_CHK_STOP_ON_ERR_EN` defined:
  - ERROR is terminal.
  - `ref_ready` is forced to 0.
  - Counters freeze.
  - `err_cnt` is at most 1.
- `TRACE_CHK_STOP_ON_ERR_EN` undefined:
  - ERROR behaves like RUN. Each commit still pops and compares.
  - `err_cnt` increments per error.
  - DONE is reachable on the `ref_last` match, with `pass`=0 whenever `err_cnt`≠0.

## Structure
- Package `trace_chk_pkg` holds:
  - the state enum;
  - the `err_code` constants;
  - a packed `trace_entry_t` struct of {pc, wnum, wdata, last}, 70 bits.
- One sub-module, `trace_fifo`: a synchronous FIFO of `trace_entry_t` with `FIFO_DEPTH` entries, ports push/pop/full/empty/head, and asynchronous active-low reset.

## Test plan
- **Matched run:** push 3 entries (pc 0x1c000000/04/08, wnum 1/2/3, wdata 0x10/0x20/0x30, last on the third), then drive 3 matching commits. Expect `match_cnt`=3, `done`=1, `pass`=1, `err`=0.
- **Data mismatch:** commit wdata 0x31 where 0x30 is expected. Expect `err`=1, `err_code`=4, `err_pc`=0x1c000008, and `chk_state`=ERROR one cycle later.
- **Underflow:** a commit with an empty FIFO, in the same cycle as the first push. Expect `err_code`=1 and `err_exp_pc`=0.
- **Filtered events:** a commit with wnum=0, or with `debug_wb_rf_we`=0, is ignored. FIFO occupancy and `match_cnt` are unchanged.
- **Full FIFO:** hold `ref_valid` high through 8 pushes. Expect `ref_ready`=0. Pop once together with an offered push; expect no push that cycle and `ref_ready`=1 next cycle.
- **Async reset:** assert `resetn` low in mid-RUN with 5 entries buffered. Outputs clear immediately; after release, `ref_ready`=1 and the FIFO is empty.
